// File: rtl/decode_pkg.sv
// Shared opcode/funct constants and the decoded-instruction record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package decode_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_AMO    = 7'b0101111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [4:0] AMO_LR   = 5'b00010;
  localparam logic [4:0] AMO_SC   = 5'b00011;
  localparam logic [4:0] AMO_SWAP = 5'b00001;
  localparam logic [4:0] AMO_ADD  = 5'b00000;
  localparam logic [4:0] AMO_XOR  = 5'b00100;
  localparam logic [4:0] AMO_AND  = 5'b01100;
  localparam logic [4:0] AMO_OR   = 5'b01000;
  localparam logic [4:0] AMO_MIN  = 5'b10000;
  localparam logic [4:0] AMO_MAX  = 5'b10100;
  localparam logic [4:0] AMO_MINU = 5'b11000;
  localparam logic [4:0] AMO_MAXU = 5'b11100;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic lui, auipc, jal, jalr;
    logic beq, bne, blt, bge, bltu, bgeu;
    logic lb, lh, lw, lbu, lhu, sb, sh, sw;
    logic addi, slti, sltiu, xori, ori, andi, slli, srli, srai;
    logic add, sub, sll, slt, sltu, xor_, srl, sra, or_, and_;
    logic fence, fence_i, ecall, ebreak;
    logic csrrw, csrrs, csrrc, csrrwi, csrrsi, csrrci;
    logic mul, mulh, mulhsu, mulhu, div, divu, rem, remu;
    logic lr, sc, amoswap, amoadd, amoxor, amoand, amoor;
    logic amomin, amomax, amominu, amomaxu, aq, rl;
    logic rv32m, rv32a;
    logic is_load, is_store, is_conditional_jump, writes_to_reg, illegal;
  } instructions;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready valid-ready pairs.
interface decode_stage_if;
  import decode_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  instructions out_instr;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic        out_illegal;

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_instr, out_rs1, out_rs2, out_illegal
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_instr, out_rs1, out_rs2, out_illegal
  );
endinterface

// File: rtl/decode_logic.sv
// Combinational RV32IMA+Zicsr decoder: raw word + pc -> instructions record.
// Latency: 0 cycles, purely combinational.
// Backpressure: none, no state.
module decode_logic
  import decode_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1,
  parameter bit ENABLE_A = 1'b1
) (
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  output instructions o_dec
);

  logic [6:0]  w_op, w_f7;
  logic [2:0]  w_f3;
  logic [4:0]  w_f5, w_rd, w_rs1, w_rs2;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic        w_base, w_alt, w_mext;
  logic        w_legal;
  instructions w_d;

  assign w_op   = i_instr[6:0];
  assign w_rd   = i_instr[11:7];
  assign w_f3   = i_instr[14:12];
  assign w_rs1  = i_instr[19:15];
  assign w_rs2  = i_instr[24:20];
  assign w_f7   = i_instr[31:25];
  assign w_f5   = i_instr[31:27];
  assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u = {i_instr[31:12], 12'd0};
  assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
  assign w_base = (w_f7 == 7'b0000000);
  assign w_alt  = (w_f7 == 7'b0100000);
  assign w_mext = (w_f7 == 7'b0000001) && ENABLE_M;

  // Classify the word and fill format fields; anything not matched leaves w_legal low.
  always_comb begin
    w_d        = '0;
    w_legal    = 1'b0;
    w_d.pc     = i_pc;
    w_d.funct7 = w_f7;
    w_d.rd     = w_rd;
    w_d.rs1    = w_rs1;
    w_d.rs2    = w_rs2;
    w_d.imm    = w_imm_i;
    case (w_op)
      OP_LUI, OP_AUIPC: begin
        w_legal = 1'b1;
        w_d.lui = (w_op == OP_LUI);
        w_d.auipc = (w_op == OP_AUIPC);
        w_d.imm = w_imm_u; w_d.rs1 = '0; w_d.rs2 = '0; w_d.writes_to_reg = 1'b1;
      end
      OP_JAL: begin
        w_legal = 1'b1; w_d.jal = 1'b1;
        w_d.imm = w_imm_j; w_d.rs1 = '0; w_d.rs2 = '0; w_d.writes_to_reg = 1'b1;
      end
      OP_JALR: begin
        w_legal = (w_f3 == 3'b000); w_d.jalr = 1'b1;
        w_d.rs2 = '0; w_d.writes_to_reg = 1'b1;
      end
      OP_BRANCH: begin
        w_d.beq = (w_f3 == 3'b000); w_d.bne  = (w_f3 == 3'b001);
        w_d.blt = (w_f3 == 3'b100); w_d.bge  = (w_f3 == 3'b101);
        w_d.bltu = (w_f3 == 3'b110); w_d.bgeu = (w_f3 == 3'b111);
        w_legal = (w_f3 != 3'b010) && (w_f3 != 3'b011);
        w_d.imm = w_imm_b; w_d.rd = '0; w_d.is_conditional_jump = 1'b1;
      end
      OP_LOAD: begin
        w_d.lb = (w_f3 == 3'b000); w_d.lh = (w_f3 == 3'b001); w_d.lw = (w_f3 == 3'b010);
        w_d.lbu = (w_f3 == 3'b100); w_d.lhu = (w_f3 == 3'b101);
        w_legal = w_d.lb || w_d.lh || w_d.lw || w_d.lbu || w_d.lhu;
        w_d.rs2 = '0; w_d.is_load = 1'b1; w_d.writes_to_reg = 1'b1;
      end
      OP_STORE: begin
        w_d.sb = (w_f3 == 3'b000); w_d.sh = (w_f3 == 3'b001); w_d.sw = (w_f3 == 3'b010);
        w_legal = w_d.sb || w_d.sh || w_d.sw;
        w_d.imm = w_imm_s; w_d.rd = '0; w_d.is_store = 1'b1;
      end
      OP_IMM: begin
        w_d.addi = (w_f3 == 3'b000); w_d.slti = (w_f3 == 3'b010); w_d.sltiu = (w_f3 == 3'b011);
        w_d.xori = (w_f3 == 3'b100); w_d.ori  = (w_f3 == 3'b110); w_d.andi  = (w_f3 == 3'b111);
        w_d.slli = (w_f3 == 3'b001) && w_base;
        w_d.srli = (w_f3 == 3'b101) && w_base;
        w_d.srai = (w_f3 == 3'b101) && w_alt;
        w_legal = ((w_f3 != 3'b001) && (w_f3 != 3'b101)) || w_d.slli || w_d.srli || w_d.srai;
        w_d.rs2 = '0; w_d.writes_to_reg = 1'b1;
      end
      OP_OP: begin
        w_d.add  = w_base && (w_f3 == 3'b000); w_d.sll  = w_base && (w_f3 == 3'b001);
        w_d.slt  = w_base && (w_f3 == 3'b010); w_d.sltu = w_base && (w_f3 == 3'b011);
        w_d.xor_ = w_base && (w_f3 == 3'b100); w_d.srl  = w_base && (w_f3 == 3'b101);
        w_d.or_  = w_base && (w_f3 == 3'b110); w_d.and_ = w_base && (w_f3 == 3'b111);
        w_d.sub  = w_alt && (w_f3 == 3'b000);  w_d.sra  = w_alt && (w_f3 == 3'b101);
        w_d.rv32m = w_mext;
        w_d.mul  = w_mext && (w_f3 == 3'b000); w_d.mulh   = w_mext && (w_f3 == 3'b001);
        w_d.mulhsu = w_mext && (w_f3 == 3'b010); w_d.mulhu = w_mext && (w_f3 == 3'b011);
        w_d.div  = w_mext && (w_f3 == 3'b100); w_d.divu   = w_mext && (w_f3 == 3'b101);
        w_d.rem  = w_mext && (w_f3 == 3'b110); w_d.remu   = w_mext && (w_f3 == 3'b111);
        w_legal = w_base || w_d.sub || w_d.sra || w_mext;
        w_d.writes_to_reg = 1'b1;
      end
      OP_AMO: begin
        w_d.lr = (w_f5 == AMO_LR);       w_d.sc = (w_f5 == AMO_SC);
        w_d.amoswap = (w_f5 == AMO_SWAP); w_d.amoadd = (w_f5 == AMO_ADD);
        w_d.amoxor = (w_f5 == AMO_XOR);   w_d.amoand = (w_f5 == AMO_AND);
        w_d.amoor = (w_f5 == AMO_OR);     w_d.amomin = (w_f5 == AMO_MIN);
        w_d.amomax = (w_f5 == AMO_MAX);   w_d.amominu = (w_f5 == AMO_MINU);
        w_d.amomaxu = (w_f5 == AMO_MAXU);
        w_d.aq = w_f7[1]; w_d.rl = w_f7[0]; w_d.rv32a = 1'b1;
        w_legal = ENABLE_A && (w_f3 == 3'b010) &&
                  ((w_d.lr && (w_rs2 == 5'd0)) || w_d.sc || w_d.amoswap || w_d.amoadd ||
                   w_d.amoxor || w_d.amoand || w_d.amoor || w_d.amomin || w_d.amomax ||
                   w_d.amominu || w_d.amomaxu);
        w_d.writes_to_reg = 1'b1;
      end
      OP_FENCE: begin
        // rd/rs1 of fence are reserved fields and deliberately not checked.
        w_d.fence = (w_f3 == 3'b000); w_d.fence_i = (w_f3 == 3'b001);
        w_legal = w_d.fence || w_d.fence_i;
        w_d.rs2 = '0;
      end
      OP_SYSTEM: begin
        w_d.ecall  = (w_f3 == 3'b000) && (i_instr[31:20] == 12'd0);
        w_d.ebreak = (w_f3 == 3'b000) && (i_instr[31:20] == 12'd1);
        w_d.csrrw  = (w_f3 == 3'b001); w_d.csrrs  = (w_f3 == 3'b010); w_d.csrrc  = (w_f3 == 3'b011);
        w_d.csrrwi = (w_f3 == 3'b101); w_d.csrrsi = (w_f3 == 3'b110); w_d.csrrci = (w_f3 == 3'b111);
        w_legal = w_d.ecall || w_d.ebreak || ((w_f3 != 3'b000) && (w_f3 != 3'b100));
        w_d.rs2 = '0;
        w_d.writes_to_reg = (w_f3 != 3'b000) && (w_rd != 5'd0);
      end
      default: w_legal = 1'b0;
    endcase
    if (i_instr[1:0] != 2'b11) w_legal = 1'b0;
  end

  // Illegal words drop every flag and carry the raw word in imm as the trap value.
  always_comb begin
    o_dec = w_d;
    if (!w_legal) begin
      o_dec         = '0;
      o_dec.pc      = i_pc;
      o_dec.funct7  = w_f7;
      o_dec.rd      = w_rd;
      o_dec.rs1     = w_rs1;
      o_dec.rs2     = w_rs2;
      o_dec.imm     = i_instr;
      o_dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes fetched words and queues them in a DEPTH-entry FIFO.
// Latency: accept in cycle N is visible at the output in cycle N+1 at the earliest.
// Backpressure: in_ready drops when full or flushing; no pass-through while full.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter bit ENABLE_M = 1'b1,
  parameter bit ENABLE_A = 1'b1
) (
  input logic           clk,
  input logic           rstn,
  input logic           flush,
  decode_stage_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  instructions   r_mem [DEPTH];
  logic [PW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_cnt;
  instructions   w_dec, w_head;
  logic          w_push, w_pop;

  // Pointers wrap at DEPTH-1 so non-power-of-two depths stay in range.
  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  decode_logic #(.ENABLE_M(ENABLE_M), .ENABLE_A(ENABLE_A)) u_decode (
    .i_pc   (bus.in_pc),
    .i_instr(bus.in_instr),
    .o_dec  (w_dec)
  );

  // rstn gates in_ready so fetch sees no room while reset is held.
  assign bus.in_ready    = rstn && (r_cnt < FULL) && !flush;
  assign bus.out_valid   = (r_cnt != '0);
  assign w_push          = bus.in_valid && bus.in_ready;
  assign w_pop           = bus.out_valid && bus.out_ready && !flush;
  assign w_head          = r_mem[r_rd];
  assign bus.out_instr   = w_head;
  assign bus.out_rs1     = w_head.rs1;
  assign bus.out_rs2     = w_head.rs2;
  assign bus.out_illegal = bus.out_valid && w_head.illegal;

  // Entry storage: written on accept only, never reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_dec;
  end

  // Pointer/count bookkeeping; flush empties the queue by snapping rd onto wr.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
      r_rd  <= '0;
      r_wr  <= '0;
    end else if (flush) begin
      r_cnt <= '0;
      r_rd  <= r_wr;
    end else begin
      if (w_push) r_wr <= f_next(r_wr);
      if (w_pop)  r_rd <= f_next(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, FIFO ordering, full and flush.
// Latency: checks next-cycle visibility of accepted entries.
// Backpressure: drives out_ready low/high to fill, drain and wrap the queue.
module tb_decode_stage;
  import decode_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  logic flush;
  int   total = 0;
  int   bad   = 0;

  decode_stage_if bus ();
  decode_stage_if bus_n ();

  assign bus_n.in_valid  = bus.in_valid;
  assign bus_n.in_pc     = bus.in_pc;
  assign bus_n.in_instr  = bus.in_instr;
  assign bus_n.out_ready = bus.out_ready;

  decode_stage #(.DEPTH(2)) dut (.clk(clk), .rstn(rstn), .flush(flush), .bus(bus));
  decode_stage #(.DEPTH(2), .ENABLE_M(1'b0), .ENABLE_A(1'b0)) dut_n (
    .clk(clk), .rstn(rstn), .flush(flush), .bus(bus_n));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [31:0] pc, input logic [31:0] instr);
    bus.in_valid = 1'b1; bus.in_pc = pc; bus.in_instr = instr;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0; bus.out_ready = 1'b0;
    repeat (3) tick();
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0h want=0", bus.in_ready); end
    rstn = 1'b1; #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%0h want=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0h want=0", bus.out_valid); end
    total++; if (bus.out_illegal !== 1'b0) begin bad++; $display("FAIL rst_out_illegal got=%0h want=0", bus.out_illegal); end
  endtask

  task automatic test_addi();
    bus.in_valid = 1'b1; bus.in_pc = 32'h100; bus.in_instr = 32'hFFF10093; #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL addi_same_cycle got=%0h want=0", bus.out_valid); end
    tick(); bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%0h want=1", bus.out_valid); end
    total++; if (bus.out_instr.addi !== 1'b1) begin bad++; $display("FAIL addi_flag got=%0h want=1", bus.out_instr.addi); end
    total++; if (bus.out_instr.rd !== 5'd1) begin bad++; $display("FAIL addi_rd got=%0d want=1", bus.out_instr.rd); end
    total++; if (bus.out_rs1 !== 5'd2) begin bad++; $display("FAIL addi_rs1 got=%0d want=2", bus.out_rs1); end
    total++; if (bus.out_instr.imm !== 32'hFFFFFFFF) begin bad++; $display("FAIL addi_imm got=%h want=ffffffff", bus.out_instr.imm); end
    total++; if (bus.out_instr.writes_to_reg !== 1'b1) begin bad++; $display("FAIL addi_wtr got=%0h want=1", bus.out_instr.writes_to_reg); end
    total++; if (bus.out_illegal !== 1'b0) begin bad++; $display("FAIL addi_illegal got=%0h want=0", bus.out_illegal); end
    total++; if (bus.out_instr.pc !== 32'h100) begin bad++; $display("FAIL addi_pc got=%h want=00000100", bus.out_instr.pc); end
    drain();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL addi_drained got=%0h want=0", bus.out_valid); end
  endtask

  task automatic test_lui_beq();
    load(32'h104, 32'h123452B7);
    total++; if (bus.out_instr.lui !== 1'b1) begin bad++; $display("FAIL lui_flag got=%0h want=1", bus.out_instr.lui); end
    total++; if (bus.out_instr.imm !== 32'h12345000) begin bad++; $display("FAIL lui_imm got=%h want=12345000", bus.out_instr.imm); end
    total++; if (bus.out_rs1 !== 5'd0 || bus.out_rs2 !== 5'd0) begin bad++; $display("FAIL lui_rs_zero got=%0d/%0d want=0/0", bus.out_rs1, bus.out_rs2); end
    total++; if (bus.out_instr.rd !== 5'd5) begin bad++; $display("FAIL lui_rd got=%0d want=5", bus.out_instr.rd); end
    drain();
    load(32'h108, 32'hFE000EE3);
    total++; if (bus.out_instr.beq !== 1'b1) begin bad++; $display("FAIL beq_flag got=%0h want=1", bus.out_instr.beq); end
    total++; if (bus.out_instr.imm !== 32'hFFFFFFFC) begin bad++; $display("FAIL beq_imm got=%h want=fffffffc", bus.out_instr.imm); end
    total++; if (bus.out_instr.rd !== 5'd0) begin bad++; $display("FAIL beq_rd got=%0d want=0", bus.out_instr.rd); end
    total++; if (bus.out_instr.writes_to_reg !== 1'b0) begin bad++; $display("FAIL beq_wtr got=%0h want=0", bus.out_instr.writes_to_reg); end
    total++; if (bus.out_instr.is_conditional_jump !== 1'b1) begin bad++; $display("FAIL beq_cond got=%0h want=1", bus.out_instr.is_conditional_jump); end
    drain();
  endtask

  task automatic test_ext();
    load(32'h10C, 32'h022081B3);
    total++; if (bus.out_instr.mul !== 1'b1) begin bad++; $display("FAIL mul_flag got=%0h want=1", bus.out_instr.mul); end
    total++; if (bus.out_instr.rd !== 5'd3 || bus.out_rs1 !== 5'd1 || bus.out_rs2 !== 5'd2) begin bad++; $display("FAIL mul_regs got=%0d/%0d/%0d want=3/1/2", bus.out_instr.rd, bus.out_rs1, bus.out_rs2); end
    total++; if (bus.out_illegal !== 1'b0) begin bad++; $display("FAIL mul_illegal got=%0h want=0", bus.out_illegal); end
    total++; if (bus_n.out_illegal !== 1'b1) begin bad++; $display("FAIL nom_illegal got=%0h want=1", bus_n.out_illegal); end
    total++; if (bus_n.out_instr.imm !== 32'h022081B3) begin bad++; $display("FAIL nom_imm got=%h want=022081b3", bus_n.out_instr.imm); end
    total++; if (bus_n.out_instr.mul !== 1'b0 || bus_n.out_instr.rv32m !== 1'b0 || bus_n.out_instr.writes_to_reg !== 1'b0) begin bad++; $display("FAIL nom_flags got=%0h%0h%0h want=000", bus_n.out_instr.mul, bus_n.out_instr.rv32m, bus_n.out_instr.writes_to_reg); end
    drain();
    load(32'h110, 32'h0063A2AF);
    total++; if (bus.out_instr.amoadd !== 1'b1 || bus.out_instr.rv32a !== 1'b1) begin bad++; $display("FAIL amo_flags got=%0h%0h want=11", bus.out_instr.amoadd, bus.out_instr.rv32a); end
    total++; if (bus.out_instr.rd !== 5'd5 || bus.out_rs1 !== 5'd7 || bus.out_rs2 !== 5'd6) begin bad++; $display("FAIL amo_regs got=%0d/%0d/%0d want=5/7/6", bus.out_instr.rd, bus.out_rs1, bus.out_rs2); end
    total++; if (bus_n.out_illegal !== 1'b1) begin bad++; $display("FAIL noa_illegal got=%0h want=1", bus_n.out_illegal); end
    drain();
  endtask

  task automatic test_system_illegal();
    load(32'h114, 32'h30029073);
    total++; if (bus.out_instr.csrrw !== 1'b1 || bus.out_rs1 !== 5'd5) begin bad++; $display("FAIL csrrw got=%0h rs1=%0d want=1 rs1=5", bus.out_instr.csrrw, bus.out_rs1); end
    total++; if (bus.out_instr.writes_to_reg !== 1'b0) begin bad++; $display("FAIL csr_rd0_wtr got=%0h want=0", bus.out_instr.writes_to_reg); end
    drain();
    load(32'h118, 32'h00100073);
    total++; if (bus.out_instr.ebreak !== 1'b1 || bus.out_instr.ecall !== 1'b0) begin bad++; $display("FAIL ebreak got=%0h%0h want=10", bus.out_instr.ebreak, bus.out_instr.ecall); end
    drain();
    load(32'h11C, 32'h00000000);
    total++; if (bus.out_illegal !== 1'b1) begin bad++; $display("FAIL zero_illegal got=%0h want=1", bus.out_illegal); end
    total++; if (bus.out_instr.writes_to_reg !== 1'b0 || bus.out_instr.is_load !== 1'b0 || bus.out_instr.imm !== 32'h0) begin bad++; $display("FAIL zero_fields got=%0h%0h imm=%h want=00 imm=0", bus.out_instr.writes_to_reg, bus.out_instr.is_load, bus.out_instr.imm); end
    drain();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_instr = 32'h13; bus.in_pc = 32'h200; #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_rdy0 got=%0h want=1", bus.in_ready); end
    tick(); bus.in_pc = 32'h204;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_rdy1 got=%0h want=1", bus.in_ready); end
    tick(); bus.in_pc = 32'h208;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full got=%0h want=0", bus.in_ready); end
    tick();
    total++; if (bus.in_ready !== 1'b0 || bus.out_instr.pc !== 32'h200) begin bad++; $display("FAIL b2b_hold got=%0h pc=%h want=0 pc=00000200", bus.in_ready, bus.out_instr.pc); end
    bus.out_ready = 1'b1; #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_pop_no_raise got=%0h want=0", bus.in_ready); end
    tick();
    total++; if (bus.in_ready !== 1'b1 || bus.out_instr.pc !== 32'h204) begin bad++; $display("FAIL b2b_after_pop got=%0h pc=%h want=1 pc=00000204", bus.in_ready, bus.out_instr.pc); end
    tick(); bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.out_instr.pc !== 32'h208) begin bad++; $display("FAIL b2b_third got=%0h pc=%h want=1 pc=00000208", bus.out_valid, bus.out_instr.pc); end
    tick(); bus.out_ready = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%0h want=0", bus.out_valid); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_q[$];
    int pushed = 0;
    int popped = 0;
    logic acc, pop;
    for (int cyc = 0; cyc < 200 && popped < 10; cyc++) begin
      bus.in_valid  = (pushed < 10);
      bus.in_pc     = 32'h1000 + 32'(pushed * 4);
      bus.in_instr  = 32'h13;
      bus.out_ready = ((cyc % 3) != 1);
      #1;
      acc = bus.in_valid && bus.in_ready;
      pop = bus.out_valid && bus.out_ready;
      if (pop) begin
        total++;
        if (exp_q.size() == 0 || bus.out_instr.pc !== exp_q[0]) begin bad++; $display("FAIL wrap_order got=%h entry=%0d", bus.out_instr.pc, popped); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        popped++;
      end
      if (acc) begin exp_q.push_back(bus.in_pc); pushed++; end
      tick();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; #1;
    total++; if (popped != 10) begin bad++; $display("FAIL wrap_timeout got=%0d want=10", popped); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL wrap_empty got=%0h want=0", bus.out_valid); end
  endtask

  task automatic test_flush();
    load(32'h300, 32'h13);
    flush = 1'b1; bus.in_valid = 1'b1; bus.in_pc = 32'h304; bus.out_ready = 1'b1; #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_rdy got=%0h want=0", bus.in_ready); end
    tick(); flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_one got=%0h want=0", bus.out_valid); end
    load(32'h308, 32'h13);
    load(32'h30C, 32'h13);
    total++; if (bus.out_valid !== 1'b1 || bus.out_instr.pc !== 32'h308) begin bad++; $display("FAIL flush_refill got=%0h pc=%h want=1 pc=00000308", bus.out_valid, bus.out_instr.pc); end
    flush = 1'b1; bus.in_valid = 1'b1; bus.in_pc = 32'h310; #1;
    tick(); flush = 1'b0; bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_two got=%0h want=0", bus.out_valid); end
    load(32'h314, 32'h13);
    total++; if (bus.out_valid !== 1'b1 || bus.out_instr.pc !== 32'h314) begin bad++; $display("FAIL flush_next got=%0h pc=%h want=1 pc=00000314", bus.out_valid, bus.out_instr.pc); end
    drain();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_alone got=%0h want=0", bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lui_beq();
    test_ext();
    test_system_illegal();
    test_back_to_back();
    test_wrap();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
